// File: rtl/game_ctrl_pkg.sv
// Shared types and IR code constants for the game flow sequencer and menu logic.
// The PAUSED encoding is always defined here. It is only reachable when GAME_FLOW_PAUSE_EN is defined.
package game_ctrl_pkg;

  localparam int unsigned IR_CODE_W = 32;
  localparam int unsigned HEALTH_W  = 3;
  localparam int unsigned DIGIT_W   = 2;
  localparam int unsigned STATE_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_START     = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_WIN       = 3'd4,
    ST_LOSE      = 3'd5
  } game_state_t;

  typedef enum logic [1:0] {
    IR_NONE    = 2'd0,
    IR_START   = 2'd1,
    IR_RESTART = 2'd2,
    IR_PAUSE   = 2'd3
  } ir_cmd_t;

  // Remote ships two different codes for the start button.
  localparam logic [IR_CODE_W-1:0] IR_CODE_START_A = 32'h20DF_5BA4;
  localparam logic [IR_CODE_W-1:0] IR_CODE_START_B = 32'h20DF_5AA5;
  localparam logic [IR_CODE_W-1:0] IR_CODE_RESTART = 32'h20DF_10EF;
  localparam logic [IR_CODE_W-1:0] IR_CODE_PAUSE   = 32'h20DF_906F;

  // Larger of two unsigned values, used when sizing shared counters.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ir_cmd_decode.sv
// Combinational IR command decoder: a qualified NEC code becomes a game command.
// Unknown codes and unqualified cycles decode to IR_NONE.
module ir_cmd_decode
  import game_ctrl_pkg::*;
(
  input  logic                 valid,
  input  logic [IR_CODE_W-1:0] code,
  output ir_cmd_t              cmd_c
);

  // Map the raw code to a command when the strobe is high.
  always_comb begin
    cmd_c = IR_NONE;
    if (valid) begin
      case (code)
        IR_CODE_START_A,
        IR_CODE_START_B: cmd_c = IR_START;
        IR_CODE_RESTART: cmd_c = IR_RESTART;
        IR_CODE_PAUSE:   cmd_c = IR_PAUSE;
        default:         cmd_c = IR_NONE;
      endcase
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: START -> COUNTDOWN -> PLAY -> WIN/LOSE -> START.
// This is a Moore FSM. Every output is registered and is computed from the next state.
// Optional feature macro: GAME_FLOW_PAUSE_EN adds the PAUSED state, toggled by CMD_PAUSE.
module game_flow_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned COUNTDOWN_FRAMES = 60,
  parameter int unsigned COUNTDOWN_START  = 3,
  parameter int unsigned END_HOLD_FRAMES  = 180
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 nf_in,
  input  logic                 ir_valid_in,
  input  logic [IR_CODE_W-1:0] ir_in,
  input  logic [HEALTH_W-1:0]  player_health_in,
  input  logic [HEALTH_W-1:0]  opponent_health_in,
  output logic [STATE_W-1:0]   state_out,
  output logic                 display_start_out,
  output logic                 play_active_out,
  output logic [DIGIT_W-1:0]   countdown_out,
  output logic                 round_start_out,
  output logic                 end_win_out,
  output logic                 end_lose_out
);

  localparam int unsigned FRAME_W = $clog2(max_u(COUNTDOWN_FRAMES, END_HOLD_FRAMES) + 1);
  localparam logic [FRAME_W-1:0] CD_LAST     = FRAME_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [FRAME_W-1:0] HOLD_MAX    = FRAME_W'(END_HOLD_FRAMES);
  localparam logic [DIGIT_W-1:0] DIGIT_FIRST = DIGIT_W'(COUNTDOWN_START);
  localparam logic [DIGIT_W-1:0] DIGIT_ONE   = DIGIT_W'(1);

  logic [1:0]         rst_sync;
  logic               rst_n;
  ir_cmd_t            cmd;
  game_state_t        state_q;
  game_state_t        state_nxt;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_nxt;
  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_nxt;
  logic               round_start_nxt;

  // Reset is asserted asynchronously and released on a clock edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  ir_cmd_decode u_ir_cmd_decode (
    .valid (ir_valid_in),
    .code  (ir_in),
    .cmd_c (cmd)
  );

  // Next state and counters. An IR transition takes priority over a coincident frame tick.
  always_comb begin
    state_nxt       = state_q;
    frame_nxt       = frame_q;
    digit_nxt       = digit_q;
    round_start_nxt = 1'b0;
    case (state_q)
      ST_START: begin
        if (cmd == IR_START) begin
          state_nxt = ST_COUNTDOWN;
          digit_nxt = DIGIT_FIRST;
          frame_nxt = '0;
        end
      end
      ST_COUNTDOWN: begin
        if (cmd == IR_RESTART) begin
          state_nxt = ST_START;
          frame_nxt = '0;
          digit_nxt = '0;
        end else if (nf_in) begin
          if (frame_q == CD_LAST) begin
            frame_nxt = '0;
            if (digit_q == DIGIT_ONE) begin
              state_nxt       = ST_PLAY;
              digit_nxt       = '0;
              round_start_nxt = 1'b1;
            end else begin
              digit_nxt = digit_q - DIGIT_ONE;
            end
          end else begin
            frame_nxt = frame_q + FRAME_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (cmd == IR_RESTART) begin
          state_nxt = ST_START;
          frame_nxt = '0;
          digit_nxt = '0;
        end
`ifdef GAME_FLOW_PAUSE_EN
        else if (cmd == IR_PAUSE) begin
          state_nxt = ST_PAUSED;
        end
`endif
        // Health is ignored during the reload cycle. A dead player takes priority over a dead opponent.
        else if (!round_start_out) begin
          if (player_health_in == '0) begin
            state_nxt = ST_LOSE;
            frame_nxt = '0;
          end else if (opponent_health_in == '0) begin
            state_nxt = ST_WIN;
            frame_nxt = '0;
          end
        end
      end
      ST_PAUSED: begin
`ifdef GAME_FLOW_PAUSE_EN
        if (cmd == IR_RESTART) begin
          state_nxt = ST_START;
          frame_nxt = '0;
          digit_nxt = '0;
        end else if (cmd == IR_PAUSE) begin
          state_nxt = ST_PLAY;
        end
`else
        state_nxt = ST_START;
        frame_nxt = '0;
        digit_nxt = '0;
`endif
      end
      ST_WIN, ST_LOSE: begin
        // A restart is only accepted once the hold time has elapsed. An early restart is dropped.
        if (cmd == IR_RESTART && frame_q == HOLD_MAX) begin
          state_nxt = ST_START;
          frame_nxt = '0;
        end else if (nf_in && frame_q != HOLD_MAX) begin
          frame_nxt = frame_q + FRAME_W'(1);
        end
      end
      default: begin
        state_nxt = ST_START;
        frame_nxt = '0;
        digit_nxt = '0;
      end
    endcase
  end

  // State, counters and registered screen flags derived from the next state.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_START;
      frame_q           <= '0;
      digit_q           <= '0;
      display_start_out <= 1'b1;
      play_active_out   <= 1'b0;
      countdown_out     <= '0;
      round_start_out   <= 1'b0;
      end_win_out       <= 1'b0;
      end_lose_out      <= 1'b0;
    end else begin
      state_q           <= state_nxt;
      frame_q           <= frame_nxt;
      digit_q           <= digit_nxt;
      display_start_out <= (state_nxt == ST_START);
      play_active_out   <= (state_nxt == ST_PLAY);
      countdown_out     <= (state_nxt == ST_COUNTDOWN) ? digit_nxt : '0;
      round_start_out   <= round_start_nxt;
      end_win_out       <= (state_nxt == ST_WIN);
      end_lose_out      <= (state_nxt == ST_LOSE);
    end
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed testbench for game_flow_ctrl with default parameters.
// Pause checks are built when GAME_FLOW_PAUSE_EN is defined. Otherwise the bench checks that CMD_PAUSE is ignored.
module tb_game_flow_ctrl;

  localparam logic [31:0] C_START_A = 32'h20DF_5BA4;
  localparam logic [31:0] C_START_B = 32'h20DF_5AA5;
  localparam logic [31:0] C_RESTART = 32'h20DF_10EF;
  localparam logic [31:0] C_PAUSE   = 32'h20DF_906F;
  localparam logic [31:0] C_UNKNOWN = 32'h20DF_0000;

  localparam int S_START = 0;
  localparam int S_CD    = 1;
  localparam int S_PLAY  = 2;
  localparam int S_PAUSE = 3;
  localparam int S_WIN   = 4;
  localparam int S_LOSE  = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        nf;
  logic        ir_valid;
  logic [31:0] ir;
  logic [2:0]  player_h;
  logic [2:0]  opp_h;
  logic [2:0]  state;
  logic        display_start;
  logic        play_active;
  logic [1:0]  countdown;
  logic        round_start;
  logic        end_win;
  logic        end_lose;
  logic [9:0]  outs;

  int tests  = 0;
  int failed = 0;

  game_flow_ctrl dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .nf_in              (nf),
    .ir_valid_in        (ir_valid),
    .ir_in              (ir),
    .player_health_in   (player_h),
    .opponent_health_in (opp_h),
    .state_out          (state),
    .display_start_out  (display_start),
    .play_active_out    (play_active),
    .countdown_out      (countdown),
    .round_start_out    (round_start),
    .end_win_out        (end_win),
    .end_lose_out       (end_lose)
  );

  always #5 clk = ~clk;

  assign outs = {state, display_start, play_active, countdown, round_start, end_win, end_lose};

  // Packs the expected outputs in the same field order as outs.
  function automatic logic [9:0] o(input int st, input int ds, input int pa, input int cd,
                                   input int rs, input int w, input int l);
    return {3'(st), 1'(ds), 1'(pa), 2'(cd), 1'(rs), 1'(w), 1'(l)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_nf();
    nf = 1'b1;
    tick();
    nf = 1'b0;
    tick();
  endtask

  task automatic send_ir(input logic [31:0] code);
    ir_valid = 1'b1;
    ir       = code;
    tick();
    ir_valid = 1'b0;
    ir       = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n    = 1'b1;
    player_h = 3'd7;
    opp_h    = 3'd7;
    repeat (3) tick();
  endtask

  task automatic go_play();
    send_ir(C_START_A);
    repeat (180) pulse_nf();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    nf       = 1'b0;
    ir_valid = 1'b0;
    ir       = '0;
    player_h = 3'd7;
    opp_h    = 3'd7;
    repeat (3) tick();
    check("reset_hold", outs, o(S_START, 1, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    repeat (3) tick();
    check("reset_idle", outs, o(S_START, 1, 0, 0, 0, 0, 0));

    // Commands that must leave START alone.
    send_ir(C_RESTART);
    check("start_restart_noop", outs, o(S_START, 1, 0, 0, 0, 0, 0));
    ir = C_START_A;
    tick();
    ir = '0;
    check("start_unqualified", outs, o(S_START, 1, 0, 0, 0, 0, 0));
    send_ir(C_UNKNOWN);
    check("start_unknown", outs, o(S_START, 1, 0, 0, 0, 0, 0));

    // Test 1: full countdown into PLAY.
    send_ir(C_START_A);
    check("cd_enter", outs, o(S_CD, 0, 0, 3, 0, 0, 0));
    repeat (59) pulse_nf();
    check("cd_digit3_last", countdown, 2'd3);
    pulse_nf();
    check("cd_digit2", countdown, 2'd2);
    repeat (60) pulse_nf();
    check("cd_digit1", countdown, 2'd1);
    repeat (59) pulse_nf();
    check("cd_digit1_last", outs, o(S_CD, 0, 0, 1, 0, 0, 0));
    nf = 1'b1;
    tick();
    nf = 1'b0;
    check("play_round_start", outs, o(S_PLAY, 0, 1, 0, 1, 0, 0));
    tick();
    check("play_round_start_off", outs, o(S_PLAY, 0, 1, 0, 0, 0, 0));

    // Test 2: opponent dies.
    opp_h = 3'd0;
    tick();
    check("win_enter", outs, o(S_WIN, 0, 0, 0, 0, 1, 0));
    opp_h = 3'd7;

    // Test 4: restart is dropped until the hold time has elapsed.
    repeat (100) pulse_nf();
    send_ir(C_RESTART);
    check("win_restart_100", outs, o(S_WIN, 0, 0, 0, 0, 1, 0));
    repeat (79) pulse_nf();
    send_ir(C_RESTART);
    check("win_restart_179", outs, o(S_WIN, 0, 0, 0, 0, 1, 0));
    pulse_nf();
    send_ir(C_RESTART);
    check("win_restart_180", outs, o(S_START, 1, 0, 0, 0, 0, 0));

    // Test 3: both healths die, first checked after the round_start cycle, and LOSE wins.
    send_ir(C_START_B);
    check("cd_enter_alt_code", outs, o(S_CD, 0, 0, 3, 0, 0, 0));
    repeat (179) pulse_nf();
    player_h = 3'd0;
    opp_h    = 3'd0;
    nf = 1'b1;
    tick();
    nf = 1'b0;
    check("dead_play_round_start", outs, o(S_PLAY, 0, 1, 0, 1, 0, 0));
    tick();
    check("dead_skip_health", outs, o(S_PLAY, 0, 1, 0, 0, 0, 0));
    tick();
    check("both_dead_lose", outs, o(S_LOSE, 0, 0, 0, 0, 0, 1));

    // Test 5: asynchronous reset in the middle of a countdown.
    apply_reset();
    send_ir(C_START_A);
    repeat (30) pulse_nf();
    check("cd_before_async", outs, o(S_CD, 0, 0, 3, 0, 0, 0));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs, o(S_START, 1, 0, 0, 0, 0, 0));
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // A restart coincident with a frame tick returns to START.
    send_ir(C_START_A);
    repeat (30) pulse_nf();
    nf       = 1'b1;
    ir_valid = 1'b1;
    ir       = C_RESTART;
    tick();
    nf       = 1'b0;
    ir_valid = 1'b0;
    ir       = '0;
    check("cd_restart_with_nf", outs, o(S_START, 1, 0, 0, 0, 0, 0));
    send_ir(C_START_A);
    repeat (59) pulse_nf();
    check("cd_recount_59", countdown, 2'd3);
    pulse_nf();
    check("cd_recount_60", countdown, 2'd2);

    // A restart during PLAY returns to START.
    apply_reset();
    go_play();
    check("play_reached", outs, o(S_PLAY, 0, 1, 0, 0, 0, 0));
    send_ir(C_RESTART);
    check("play_restart", outs, o(S_START, 1, 0, 0, 0, 0, 0));

`ifdef GAME_FLOW_PAUSE_EN
    // Test 6: pause suspends health checks, and resuming gives no round_start pulse.
    go_play();
    send_ir(C_PAUSE);
    check("pause_enter", outs, o(S_PAUSE, 0, 0, 0, 0, 0, 0));
    player_h = 3'd0;
    repeat (3) pulse_nf();
    check("pause_hold_dead", outs, o(S_PAUSE, 0, 0, 0, 0, 0, 0));
    send_ir(C_PAUSE);
    check("pause_resume", outs, o(S_PLAY, 0, 1, 0, 0, 0, 0));
    tick();
    check("pause_resume_lose", outs, o(S_LOSE, 0, 0, 0, 0, 0, 1));
    apply_reset();
    go_play();
    send_ir(C_PAUSE);
    send_ir(C_RESTART);
    check("pause_restart", outs, o(S_START, 1, 0, 0, 0, 0, 0));
`else
    // Without the pause feature, CMD_PAUSE is ignored.
    go_play();
    send_ir(C_PAUSE);
    check("pause_ignored", outs, o(S_PLAY, 0, 1, 0, 0, 0, 0));
    player_h = 3'd0;
    tick();
    check("pause_ignored_lose", outs, o(S_LOSE, 0, 0, 0, 0, 0, 1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
